// File: rtl/rtc_bus_pkg.sv
// Shared types, constants and helpers for the RTC bus arbiter.
package rtc_bus_pkg;

    // Arbiter FSM states.
    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } rtc_bus_state_t;

    // Counter value of the function generator at which the bus may change hands.
    localparam logic [6:0] SAFE_POINT_DEFAULT = 7'h4A;

    // Widest request vector the priority encoder handles; callers zero-extend.
    localparam int MAX_CH = 32;

    // Priority encoder: keeps only the lowest set bit (bit 0 = highest priority).
    function automatic logic [MAX_CH-1:0] one_hot_lowest(input logic [MAX_CH-1:0] vec);
        return vec & (~vec + MAX_CH'(1));
    endfunction

endpackage

// File: rtl/rtc_bus_mux.sv
// One-hot N-way address/data mux with a read-scanner fallback when nothing is selected.
module rtc_bus_mux #(
    parameter int N_CH = 5,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic [N_CH-1:0]    sel,
    input  logic [N_CH*AW-1:0] addr_in,
    input  logic [N_CH*DW-1:0] data_in,
    input  logic [AW-1:0]      addr_fb,
    output logic [AW-1:0]      address,
    output logic [DW-1:0]      data
);

    // AND-OR selection; an all-zero select drives the read address with zero data.
    always_comb begin
        address = '0;
        data    = '0;
        if (sel == '0) begin
            address = addr_fb;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (sel[i]) begin
                    address = address | addr_in[i*AW +: AW];
                    data    = data    | data_in[i*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/rtc_bus_arbiter.sv
// Fixed-priority arbiter for the shared RTC bus with power-up init window.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_INIT | init window: channel 0 forced granted, requests ignored
//   ST_ARB  | normal arbitration at each transaction-safe point
//
// The INIT->ARB edge is itself an arbitration: the grant moves straight to the
// lowest pending request (or read mode), so a request held through the window
// is served on the edge that ends it. Collision is only recorded in ST_ARB.
module rtc_bus_arbiter
    import rtc_bus_pkg::*;
#(
    parameter int              N_CH        = 5,
    parameter int              AW          = 8,
    parameter int              DW          = 8,
    parameter int              CNT_W       = 7,
    parameter logic [CNT_W-1:0] SAFE_POINT = CNT_W'(SAFE_POINT_DEFAULT),
    parameter int              INIT_CYCLES = 1035
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_CH-1:0]     req,
    input  logic [N_CH*AW-1:0]  addr_wr,
    input  logic [N_CH*DW-1:0]  data_wr,
    input  logic [AW-1:0]       addr_rd,
    input  logic [CNT_W-1:0]    bus_cnt,
    output logic [AW-1:0]       address,
    output logic [DW-1:0]       data,
    output logic [N_CH-1:0]     grant,
    output logic                write_mode,
    output logic                init_active,
    output logic                collision
);

    localparam int INIT_W = (INIT_CYCLES < 2) ? 1 : $clog2(INIT_CYCLES + 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES);

    rtc_bus_state_t    state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
    logic              collision_q, collision_d;

    logic              safe_pt;
    logic              init_done;
    logic              owner_req;
    logic [N_CH-1:0]   grant_lowest;

    assign safe_pt      = (bus_cnt == SAFE_POINT);
    assign init_done    = (init_cnt_q == INIT_LAST);
    assign owner_req    = |(grant_q & req);
    // N_CH must not exceed MAX_CH; upper encoder bits are always zero here.
    assign grant_lowest = N_CH'(one_hot_lowest(MAX_CH'(req)));

    // State, grant, init counter and sticky collision registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_INIT;
            grant_q     <= N_CH'(1);
            init_cnt_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            init_cnt_q  <= init_cnt_d;
            collision_q <= collision_d;
        end
    end

    // Next-state logic: grant only moves on a safe-point edge.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        init_cnt_d  = init_cnt_q;
        collision_d = collision_q;
        unique case (state_q)
            ST_INIT: begin
                grant_d = N_CH'(1);
                if (!init_done) begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
                if (init_done && safe_pt) begin
                    state_d = ST_ARB;
                    grant_d = grant_lowest;
                end
            end
            ST_ARB: begin
                if (safe_pt) begin
                    if (!owner_req) begin
                        grant_d = grant_lowest;
                    end
                    if ($countones(req) > 1) begin
                        collision_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
                grant_d = N_CH'(1);
            end
        endcase
    end

    assign grant       = grant_q;
    assign write_mode  = |grant_q;
    assign init_active = (state_q == ST_INIT);
    assign collision   = collision_q;

    rtc_bus_mux #(
        .N_CH (N_CH),
        .AW   (AW),
        .DW   (DW)
    ) u_mux (
        .sel     (grant_q),
        .addr_in (addr_wr),
        .data_in (data_wr),
        .addr_fb (addr_rd),
        .address (address),
        .data    (data)
    );

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter with a cycle-level behavioural model.
module tb_rtc_bus_arbiter;

    localparam int N_CH = 5;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int CNT_W = 7;
    localparam int INIT_CYC = 16;
    localparam logic [CNT_W-1:0] SAFE = 7'h4A;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic [N_CH-1:0]     req = '0;
    logic [N_CH*AW-1:0]  addr_wr;
    logic [N_CH*DW-1:0]  data_wr;
    logic [AW-1:0]       addr_rd = 8'h55;
    logic [CNT_W-1:0]    bus_cnt = 7'h3E;
    logic [AW-1:0]       address;
    logic [DW-1:0]       data;
    logic [N_CH-1:0]     grant;
    logic                write_mode;
    logic                init_active;
    logic                collision;

    int checks = 0;
    int errors = 0;

    rtc_bus_arbiter #(
        .N_CH        (N_CH),
        .AW          (AW),
        .DW          (DW),
        .CNT_W       (CNT_W),
        .SAFE_POINT  (SAFE),
        .INIT_CYCLES (INIT_CYC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .addr_wr     (addr_wr),
        .data_wr     (data_wr),
        .addr_rd     (addr_rd),
        .bus_cnt     (bus_cnt),
        .address     (address),
        .data        (data),
        .grant       (grant),
        .write_mode  (write_mode),
        .init_active (init_active),
        .collision   (collision)
    );

    always #5 clk = ~clk;

    // Channel i: address 0x10+i, data 0xA0+i.
    initial begin
        for (int i = 0; i < N_CH; i++) begin
            addr_wr[i*AW +: AW] = 8'(8'h10 + i);
            data_wr[i*DW +: DW] = 8'(8'hA0 + i);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = read mode), edge count since reset.
    bit m_init;
    int m_edges;
    int m_owner;
    bit m_coll;

    function automatic int lowest_req(input logic [N_CH-1:0] r);
        for (int i = 0; i < N_CH; i++) if (r[i]) return i;
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_init  = 1'b1;
            m_edges = 0;
            m_owner = 0;
            m_coll  = 1'b0;
        end else if (m_init) begin
            if (m_edges >= INIT_CYC && bus_cnt == SAFE) begin
                m_init  = 1'b0;
                m_owner = lowest_req(req);
            end
            m_edges++;
        end else if (bus_cnt == SAFE) begin
            if ($countones(req) > 1) m_coll = 1'b1;
            if (!(m_owner >= 0 && req[m_owner])) m_owner = lowest_req(req);
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [N_CH-1:0] eg;
        logic [AW-1:0]   ea;
        logic [DW-1:0]   ed;
        eg = (m_owner < 0) ? '0 : N_CH'(1 << m_owner);
        ea = (m_owner < 0) ? addr_rd : addr_wr[m_owner*AW +: AW];
        ed = (m_owner < 0) ? '0 : data_wr[m_owner*DW +: DW];
        chk("grant", 32'(grant), 32'(eg));
        chk("write_mode", 32'(write_mode), 32'(m_owner >= 0));
        chk("init_active", 32'(init_active), 32'(m_init));
        chk("collision", 32'(collision), 32'(m_coll));
        chk("address", 32'(address), 32'(ea));
        chk("data", 32'(data), 32'(ed));
    end

    // One clock; bus_cnt advances 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        bus_cnt = bus_cnt + 7'd1;
    endtask

    // Advance until the next edge will see bus_cnt == v.
    task automatic wait_cnt(input logic [CNT_W-1:0] v);
        int n;
        n = 0;
        while (bus_cnt != v && n < 300) begin
            tick();
            n++;
        end
        chk("wait_cnt_timeout", 32'(bus_cnt), 32'(v));
    endtask

    initial begin
        #2 reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        // Reset state, pinned literally.
        chk("rst_grant", 32'(grant), 32'h01);
        chk("rst_init_active", 32'(init_active), 32'h1);
        chk("rst_write_mode", 32'(write_mode), 32'h1);
        chk("rst_collision", 32'(collision), 32'h0);
        chk("rst_address", 32'(address), 32'h10);
        chk("rst_data", 32'(data), 32'hA0);

        // First safe point only 10 edges after release: must stay in INIT.
        wait_cnt(SAFE);
        tick();
        chk("early_sp_init", 32'(init_active), 32'h1);
        chk("early_sp_grant", 32'(grant), 32'h01);

        // Next safe point is past the window: read mode.
        wait_cnt(SAFE);
        chk("pre_exit_init", 32'(init_active), 32'h1);
        tick();
        chk("exit_init", 32'(init_active), 32'h0);
        chk("exit_grant", 32'(grant), 32'h00);
        chk("exit_wm", 32'(write_mode), 32'h0);
        addr_rd = 8'h3C;
        #1;
        chk("rd_address", 32'(address), 32'h3C);
        chk("rd_data", 32'(data), 32'h00);

        // Two requests from read mode: priority to ch1, collision sticks.
        wait_cnt(7'h10);
        req = 5'b00110;
        wait_cnt(SAFE);
        tick();
        chk("coll_grant", 32'(grant), 32'h02);
        chk("coll_flag", 32'(collision), 32'h1);
        req = 5'b00000;
        wait_cnt(SAFE);
        tick();
        chk("coll_release_grant", 32'(grant), 32'h00);
        chk("coll_sticky", 32'(collision), 32'h1);

        // req[2] raised mid-transaction waits for the safe point.
        wait_cnt(7'h10);
        req = 5'b00100;
        tick();
        chk("mid_req_frozen", 32'(grant), 32'h00);
        wait_cnt(SAFE);
        chk("pre_sp_frozen", 32'(grant), 32'h00);
        tick();
        chk("ch2_grant", 32'(grant), 32'h04);
        chk("ch2_address", 32'(address), 32'h12);
        chk("ch2_data", 32'(data), 32'hA2);
        chk("ch2_wm", 32'(write_mode), 32'h1);

        // Asynchronous reset mid-grant, with req[4] held through the new window.
        wait_cnt(7'h30);
        req = 5'b10000;
        reset = 1'b1;
        #1;
        chk("async_grant", 32'(grant), 32'h01);
        chk("async_init", 32'(init_active), 32'h1);
        chk("async_coll", 32'(collision), 32'h0);
        tick();
        tick();
        reset = 1'b0;
        wait_cnt(SAFE);
        chk("init_hold_grant", 32'(grant), 32'h01);
        tick();
        chk("ch4_grant", 32'(grant), 32'h10);
        chk("ch4_init", 32'(init_active), 32'h0);

        // No preemption: ch3 holds while ch1 also requests.
        req = 5'b01000;
        wait_cnt(SAFE);
        tick();
        chk("ch3_grant", 32'(grant), 32'h08);
        wait_cnt(7'h20);
        req = 5'b01010;
        wait_cnt(SAFE);
        tick();
        chk("no_preempt", 32'(grant), 32'h08);
        chk("hold_coll", 32'(collision), 32'h1);
        req = 5'b00010;
        wait_cnt(SAFE);
        tick();
        chk("ch1_after_drop", 32'(grant), 32'h02);
        req = 5'b00000;
        wait_cnt(SAFE);
        tick();
        chk("final_read", 32'(grant), 32'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
